// File: rtl/relu_stream_if.sv
// Stream and control bundle for relu_stream_ctrl.
//
// Signal names follow the controller's point of view: i_* are driven into
// the controller, o_* are driven by it.
//
// Handshake rule for both streams: a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holds valid and its
// data stable until that edge. Ready may depend combinationally on the
// consumer's state, but valid never depends on ready.
//
// Signals:
//   i_start, i_num_rows           tile start pulse and tile length
//   i_bound_valid/o_bound_ready   upstream bound-row stream
//   i_bound_data                  COLS lanes of BO_BW bits
//   o_act_valid/i_act_ready       downstream activated-row stream
//   o_act_data                    COLS lanes of ACT_BW bits
//   o_busy, o_done, o_row_cnt     status
//   o_state                       FSM state for debug
interface relu_stream_if #(
  parameter int COLS   = 5,
  parameter int BO_BW  = 8,
  parameter int ACT_BW = 8,
  parameter int CNT_BW = 10
);
  logic                   i_start;
  logic [CNT_BW-1:0]      i_num_rows;
  logic                   i_bound_valid;
  logic                   o_bound_ready;
  logic [BO_BW*COLS-1:0]  i_bound_data;
  logic                   o_act_valid;
  logic                   i_act_ready;
  logic [ACT_BW*COLS-1:0] o_act_data;
  logic                   o_busy;
  logic                   o_done;
  logic [CNT_BW-1:0]      o_row_cnt;
  logic [1:0]             o_state;

  // Controller side.
  modport slave (
    input  i_start, i_num_rows, i_bound_valid, i_bound_data, i_act_ready,
    output o_bound_ready, o_act_valid, o_act_data, o_busy, o_done,
           o_row_cnt, o_state
  );

  // Stimulus / environment side.
  modport master (
    output i_start, i_num_rows, i_bound_valid, i_bound_data, i_act_ready,
    input  o_bound_ready, o_act_valid, o_act_data, o_busy, o_done,
           o_row_cnt, o_state
  );
endinterface

// File: rtl/relu_stream_ctrl.sv
// relu_stream_ctrl: sequences one tile of bound-stage rows through a
// per-lane ReLU and a registered output stage, counting rows against a
// programmed tile length.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      relu_stream_if.slave (start/length, upstream and downstream
//            streams, busy/done/row count, debug state)
module relu_stream_ctrl #(
  parameter int COLS   = 5,
  parameter int BO_BW  = 8,
  parameter int ACT_BW = 8,
  parameter int CNT_BW = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  relu_stream_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int ACT_MAX = (1 << ACT_BW) - 1;

  state_e                 state_q;
  logic [CNT_BW-1:0]      len_q;
  logic [CNT_BW-1:0]      acc_cnt_q;
  logic [CNT_BW-1:0]      row_cnt_q;
  logic                   act_valid_q;
  logic [ACT_BW*COLS-1:0] act_data_q;
  logic [ACT_BW*COLS-1:0] act_data_d;

  logic bound_ready;
  logic accept;
  logic out_hs;
  logic last_accept;

  // Negative -> 0; positive values above the activation range saturate.
  function automatic logic [ACT_BW-1:0] relu_lane(input logic signed [BO_BW-1:0] x);
    int xv;
    xv = int'(x);
    if (xv < 0)             return '0;
    else if (xv > ACT_MAX)  return '1;
    else                    return ACT_BW'(xv);
  endfunction

  always_comb begin
    act_data_d = '0;
    for (int k = 0; k < COLS; k++) begin
      act_data_d[k*ACT_BW +: ACT_BW] = relu_lane(bus.i_bound_data[k*BO_BW +: BO_BW]);
    end
  end

  // Upstream may advance only when the output register is empty or is
  // being emptied this cycle, so a stall downstream stalls upstream.
  assign bound_ready = (state_q == RUN) && (!act_valid_q || bus.i_act_ready);
  assign accept      = bus.i_bound_valid && bound_ready;
  assign out_hs      = act_valid_q && bus.i_act_ready;
  assign last_accept = accept && ((acc_cnt_q + CNT_BW'(1)) == len_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      row_cnt_q   <= '0;
      act_valid_q <= 1'b0;
      act_data_q  <= '0;
    end else begin
      // Output register: a new row overrides the clear from a handshake.
      if (accept) begin
        act_data_q  <= act_data_d;
        act_valid_q <= 1'b1;
      end else if (out_hs) begin
        act_valid_q <= 1'b0;
      end

      if (accept)  acc_cnt_q <= acc_cnt_q + CNT_BW'(1);
      if (out_hs)  row_cnt_q <= row_cnt_q + CNT_BW'(1);

      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            len_q     <= bus.i_num_rows;
            acc_cnt_q <= '0;
            row_cnt_q <= '0;
            state_q   <= (bus.i_num_rows != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (last_accept) state_q <= DRAIN;
        end
        DRAIN: begin
          // The last row is sitting in the output register here.
          if (out_hs) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_bound_ready = bound_ready;
  assign bus.o_act_valid   = act_valid_q;
  assign bus.o_act_data    = act_data_q;
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_done        = (state_q == DONE);
  assign bus.o_row_cnt     = row_cnt_q;
  assign bus.o_state       = state_q;

endmodule
